// File: rtl/sm_arith_pkg.sv
// ----------------------------------------------------------------------------
// sm_arith_pkg
//   Definitions shared by the sign-magnitude multiplier and divider.
//   - Default magnitude widths for the 5x5 -> 9-bit product format.
//   - FSM state encoding for the sequential divider.
//   - Helpers for locating the sign bit and forming a canonical sign,
//     so that a zero magnitude never carries a negative sign.
// ----------------------------------------------------------------------------
package sm_arith_pkg;

    // Product-format (dividend) and operand-format (divisor) magnitude widths.
    localparam int SM_A_MAG_W = 8;
    localparam int SM_B_MAG_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } sm_state_e;

    // The sign bit sits directly above the magnitude field.
    function automatic int sm_sign_pos(input int mag_w);
        return mag_w;
    endfunction

    // Canonical sign: zero magnitudes are always reported as positive.
    function automatic logic sm_sign(input logic sign, input logic mag_is_zero);
        return sign & ~mag_is_zero;
    endfunction

endpackage

// File: rtl/sm_div_step.sv
// ----------------------------------------------------------------------------
// sm_div_step
//   One combinational restoring-division step.
//   Ports:
//     i_rem      B_MAG_W   held partial remainder (always < divisor magnitude)
//     i_bit      1         next dividend bit, MSB first
//     i_dvs_mag  B_MAG_W   divisor magnitude
//     o_rem      B_MAG_W   partial remainder after this step
//     o_q_bit    1         quotient bit produced by this step
// ----------------------------------------------------------------------------
module sm_div_step #(
    parameter int B_MAG_W = 4
) (
    input  logic [B_MAG_W-1:0] i_rem,
    input  logic               i_bit,
    input  logic [B_MAG_W-1:0] i_dvs_mag,
    output logic [B_MAG_W-1:0] o_rem,
    output logic               o_q_bit
);

    logic [B_MAG_W:0]   w_shift;
    logic [B_MAG_W-1:0] w_diff;

    // Because i_rem < divisor, the shifted value fits in B_MAG_W+1 bits.
    assign w_shift = {i_rem, i_bit};
    assign o_q_bit = (w_shift >= {1'b0, i_dvs_mag});

    // When the subtraction happens the true difference is < divisor, so the
    // modulo-2^B_MAG_W difference of the low bits is exact.
    assign w_diff = w_shift[B_MAG_W-1:0] - i_dvs_mag;
    assign o_rem  = o_q_bit ? w_diff : w_shift[B_MAG_W-1:0];

endmodule

// File: rtl/sm_seq_divider.sv
// ----------------------------------------------------------------------------
// sm_seq_divider
//   Sequential sign-magnitude restoring divider, one quotient bit per clock.
//   Inverse of the 5x5 -> 9-bit sign-magnitude multiplier.
//   Ports:
//     clk_i          rising-edge clock
//     rst_i          synchronous active-high reset
//     start_i        request, sampled only in IDLE
//     dividend_i     [A_MAG_W]=sign, [A_MAG_W-1:0]=magnitude
//     divisor_i      [B_MAG_W]=sign, [B_MAG_W-1:0]=magnitude
//     busy_o         high while the quotient bits are being produced
//     done_o         one-cycle pulse, results valid from this cycle
//     quotient_o     sign-magnitude quotient (held until next completion)
//     remainder_o    sign-magnitude remainder, sign follows the dividend
//     div_by_zero_o  last operation had a zero divisor magnitude
// ----------------------------------------------------------------------------
module sm_seq_divider
    import sm_arith_pkg::*;
#(
    parameter int A_MAG_W = SM_A_MAG_W,
    parameter int B_MAG_W = SM_B_MAG_W
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [A_MAG_W:0]   dividend_i,
    input  logic [B_MAG_W:0]   divisor_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [A_MAG_W:0]   quotient_o,
    output logic [B_MAG_W:0]   remainder_o,
    output logic               div_by_zero_o
);

    localparam int A_SIGN = sm_sign_pos(A_MAG_W);
    localparam int B_SIGN = sm_sign_pos(B_MAG_W);
    localparam int CNT_W  = (A_MAG_W > 1) ? $clog2(A_MAG_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(A_MAG_W - 1);

    sm_state_e          r_state;
    logic [CNT_W-1:0]   r_cnt;
    // Dividend bits shift out of the top while quotient bits shift in at the
    // bottom; after A_MAG_W steps this register holds the quotient magnitude.
    logic [A_MAG_W-1:0] r_dvd;
    logic [B_MAG_W-1:0] r_dvs;
    logic [B_MAG_W-1:0] r_rem;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dbz;

    logic               r_busy;
    logic               r_done;
    logic [A_MAG_W:0]   r_quot;
    logic [B_MAG_W:0]   r_remo;
    logic               r_dbz_o;

    logic [B_MAG_W-1:0] w_rem_next;
    logic               w_q_bit;
    logic               w_dvs_zero;

    assign w_dvs_zero = (divisor_i[B_MAG_W-1:0] == '0);

    sm_div_step #(
        .B_MAG_W (B_MAG_W)
    ) u_step (
        .i_rem     (r_rem),
        .i_bit     (r_dvd[A_MAG_W-1]),
        .i_dvs_mag (r_dvs),
        .o_rem     (w_rem_next),
        .o_q_bit   (w_q_bit)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_quot   <= '0;
            r_remo   <= '0;
            r_dbz_o  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_dvd    <= dividend_i[A_MAG_W-1:0];
                        r_dvs    <= divisor_i[B_MAG_W-1:0];
                        r_rem    <= '0;
                        r_cnt    <= '0;
                        r_sign_q <= dividend_i[A_SIGN] ^ divisor_i[B_SIGN];
                        r_sign_r <= dividend_i[A_SIGN];
                        r_dbz    <= w_dvs_zero;
                        if (w_dvs_zero) begin
                            // Nothing to compute; report immediately.
                            r_state <= ST_DONE;
                        end else begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end

                ST_CALC: begin
                    r_rem <= w_rem_next;
                    r_dvd <= {r_dvd[A_MAG_W-2:0], w_q_bit};
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                    end
                end

                ST_DONE: begin
                    r_done  <= 1'b1;
                    r_state <= ST_IDLE;
                    if (r_dbz) begin
                        r_quot  <= '0;
                        r_remo  <= '0;
                        r_dbz_o <= 1'b1;
                    end else begin
                        r_quot  <= {sm_sign(r_sign_q, r_dvd == '0), r_dvd};
                        r_remo  <= {sm_sign(r_sign_r, r_rem == '0), r_rem};
                        r_dbz_o <= 1'b0;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o        = r_busy;
    assign done_o        = r_done;
    assign quotient_o    = r_quot;
    assign remainder_o   = r_remo;
    assign div_by_zero_o = r_dbz_o;

endmodule

// File: tb/tb_sm_seq_divider.sv
// ----------------------------------------------------------------------------
// tb_sm_seq_divider
//   Table-driven and scoreboard-based bench for sm_seq_divider at the default
//   8-bit / 4-bit magnitude widths.
// ----------------------------------------------------------------------------
module tb_sm_seq_divider;

    typedef struct packed {
        logic [8:0] dvd;
        logic [4:0] dvs;
        logic [8:0] q;
        logic [4:0] r;
        logic       dbz;
    } vec_t;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic [8:0] dividend_i = '0;
    logic [4:0] divisor_i = '0;
    logic       busy_o;
    logic       done_o;
    logic [8:0] quotient_o;
    logic [4:0] remainder_o;
    logic       div_by_zero_o;

    int   n_checks = 0;
    int   n_fail = 0;
    int   dones_seen = 0;
    vec_t sb[$];

    sm_seq_divider dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .dividend_i    (dividend_i),
        .divisor_i     (divisor_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .quotient_o    (quotient_o),
        .remainder_o   (remainder_o),
        .div_by_zero_o (div_by_zero_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: integer division on magnitudes, truncating, no negative zero.
    function automatic vec_t model(input logic [8:0] a, input logic [4:0] b);
        vec_t e;
        int   am, bm, qm, rm;
        am = int'(a[7:0]);
        bm = int'(b[3:0]);
        e.dvd = a;
        e.dvs = b;
        if (bm == 0) begin
            e.q = '0; e.r = '0; e.dbz = 1'b1;
        end else begin
            qm = am / bm;
            rm = am % bm;
            e.q   = {(a[8] ^ b[4]) && (qm != 0), 8'(qm)};
            e.r   = {a[8] && (rm != 0), 4'(rm)};
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Scoreboard: every done pulse consumes one expectation.
    always @(posedge clk_i) begin
        #1;
        if (done_o === 1'b1) begin
            dones_seen++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done_o), 32'(0));
            end else begin
                vec_t e;
                e = sb.pop_front();
                check("quotient", 32'(quotient_o), 32'(e.q));
                check("remainder", 32'(remainder_o), 32'(e.r));
                check("div_by_zero", 32'(div_by_zero_o), 32'(e.dbz));
            end
        end
    end

    // Issue one operation from an IDLE cycle and follow it to done_o.
    task automatic run_op(input vec_t e, input int exp_lat, input int exp_busy);
        int n;
        int busy_cnt;
        bit seen;
        dividend_i = e.dvd;
        divisor_i  = e.dvs;
        start_i    = 1'b1;
        sb.push_back(e);
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        dividend_i = 9'($urandom);
        divisor_i  = 5'($urandom);
        busy_cnt   = busy_o ? 1 : 0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(posedge clk_i); #1;
            n++;
            if (done_o) seen = 1'b1;
            else if (busy_o) busy_cnt++;
        end
        if (!seen) begin
            check("done_timeout", 32'(seen), 32'(1));
        end else begin
            check("latency", 32'(n), 32'(exp_lat));
        end
        check("busy_cycles", 32'(busy_cnt), 32'(exp_busy));
        @(posedge clk_i); #1;
        check("done_pulse_width", 32'(done_o), 32'(0));
    endtask

    vec_t tbl[$];

    initial begin
        vec_t e;
        int   d0;
        int   cyc;
        int   k;
        int   times[3];

        // Spec vectors with hand-derived results.
        tbl.push_back('{dvd: 9'b1_0001_0010, dvs: 5'b1_0011, q: 9'b0_0000_0110, r: 5'b0_0000, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b1_0010_1010, dvs: 5'b0_1110, q: 9'b1_0000_0011, r: 5'b0_0000, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b0_1100_1000, dvs: 5'b0_0111, q: 9'b0_0001_1100, r: 5'b0_0100, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b1_1100_1000, dvs: 5'b0_0111, q: 9'b1_0001_1100, r: 5'b1_0100, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b0_0000_0101, dvs: 5'b1_0000, q: 9'b0_0000_0000, r: 5'b0_0000, dbz: 1'b1});
        tbl.push_back('{dvd: 9'b0_1111_1111, dvs: 5'b0_0001, q: 9'b0_1111_1111, r: 5'b0_0000, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b1_0000_0000, dvs: 5'b1_0101, q: 9'b0_0000_0000, r: 5'b0_0000, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b0_0000_0111, dvs: 5'b1_1111, q: 9'b0_0000_0000, r: 5'b0_0111, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b1_0000_0001, dvs: 5'b0_0001, q: 9'b1_0000_0001, r: 5'b0_0000, dbz: 1'b0});
        tbl.push_back('{dvd: 9'b1_1111_1111, dvs: 5'b0_1111, q: 9'b1_0001_0001, r: 5'b0_0000, dbz: 1'b0});
        for (int i = 0; i < 8; i++) tbl.push_back(model(9'($urandom), 5'($urandom)));

        // Reset state.
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_busy", 32'(busy_o), 32'(0));
        check("rst_done", 32'(done_o), 32'(0));
        check("rst_quotient", 32'(quotient_o), 32'(0));
        check("rst_remainder", 32'(remainder_o), 32'(0));
        check("rst_dbz", 32'(div_by_zero_o), 32'(0));
        rst_i = 1'b0;
        @(posedge clk_i); #1;

        // Table vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            run_op(tbl[i], tbl[i].dbz ? 1 : 9, tbl[i].dbz ? 0 : 8);
        end

        // start_i pulsed during CALC is ignored.
        d0 = dones_seen;
        e  = model(9'b0_1100_1000, 5'b0_0111);
        dividend_i = e.dvd; divisor_i = e.dvs; start_i = 1'b1;
        sb.push_back(e);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        dividend_i = 9'b0_0000_0101; divisor_i = 5'b0_0000; start_i = 1'b1;
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (30) @(posedge clk_i);
        #1;
        check("ignored_start_dones", 32'(dones_seen - d0), 32'(1));

        // start_i held high: back-to-back issue every 10 cycles.
        d0 = dones_seen;
        e  = model(9'b1_1100_1000, 5'b0_0111);
        for (int i = 0; i < 3; i++) sb.push_back(e);
        dividend_i = e.dvd; divisor_i = e.dvs; start_i = 1'b1;
        cyc = 0;
        k   = 0;
        while (k < 3 && cyc < 60) begin
            @(posedge clk_i); #1;
            cyc++;
            if (done_o) begin
                times[k] = cyc;
                k++;
                if (k == 3) start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        if (k < 3) begin
            check("b2b_timeout", 32'(k), 32'(3));
        end else begin
            check("b2b_first", 32'(times[0]), 32'(10));
            check("b2b_interval1", 32'(times[1] - times[0]), 32'(10));
            check("b2b_interval2", 32'(times[2] - times[1]), 32'(10));
        end
        repeat (15) @(posedge clk_i);
        #1;
        check("b2b_dones", 32'(dones_seen - d0), 32'(3));
        check("b2b_sb_empty", 32'(sb.size()), 32'(0));

        // Reset mid-CALC aborts with no done_o.
        e = model(9'b0_1010_1010, 5'b0_0011);
        dividend_i = e.dvd; divisor_i = e.dvs; start_i = 1'b1;
        sb.push_back(e);
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        check("abort_busy", 32'(busy_o), 32'(0));
        check("abort_done", 32'(done_o), 32'(0));
        check("abort_quotient", 32'(quotient_o), 32'(0));
        check("abort_remainder", 32'(remainder_o), 32'(0));
        check("abort_dbz", 32'(div_by_zero_o), 32'(0));
        rst_i = 1'b0;
        sb.delete();
        d0 = dones_seen;
        repeat (12) @(posedge clk_i);
        #1;
        check("abort_no_done", 32'(dones_seen - d0), 32'(0));
        run_op(model(9'b1_0010_1010, 5'b0_1110), 9, 8);
        check("final_sb_empty", 32'(sb.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
